if_fetch_unit: RTL and testbench

Instruction fetch unit for the RISC-V core. It maintains the PC and requests instruction bytes through the memory controller's IF port, one byte per granted cycle. It assembles the four bytes little-endian into a 32-bit instruction and presents it to the IF/ID register with a valid/stall handshake. Branch redirects abort an in-flight fetch. MEM-priority preemption by the controller is absorbed by holding the byte index.

---
 rtl/if_fetch_unit_if.sv | 47 ++++
 rtl/if_fetch_unit.sv | 130 +++++++++++++
 tb/tb_if_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit and its neighbours.
//   Memory-controller side : if_request_o, if_addr_o (fetch -> ctrl),
//                            if_grant_i, mem_din_i (ctrl -> fetch)
//   Branch redirect        : jump_i, jump_addr_i (core -> fetch)
//   IF/ID side             : stall_i (IF/ID -> fetch),
//                            inst_valid_o, inst_o, inst_pc_o (fetch -> IF/ID)
// The master modport is taken by the fetch unit, the slave modport by its environment.
interface if_fetch_unit_if;
    logic        if_request_o;
    logic [31:0] if_addr_o;
    logic        if_grant_i;
    logic [7:0]  mem_din_i;

    logic        jump_i;
    logic [31:0] jump_addr_i;

    logic        stall_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    modport master (
        output if_request_o,
        output if_addr_o,
        input  if_grant_i,
        input  mem_din_i,
        input  jump_i,
        input  jump_addr_i,
        input  stall_i,
        output inst_valid_o,
        output inst_o,
        output inst_pc_o
    );

    modport slave (
        input  if_request_o,
        input  if_addr_o,
        output if_grant_i,
        output mem_din_i,
        output jump_i,
        output jump_addr_i,
        output stall_i,
        input  inst_valid_o,
        input  inst_o,
        input  inst_pc_o
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit.
// Requests one instruction byte per granted cycle from the memory controller, assembles four
// bytes little-endian into a 32-bit instruction and holds it for IF/ID until accepted.
// Ports:
//   clk   - system clock, rising-edge
//   rst_n - synchronous active-low reset
//   rdy   - global ready; low freezes everything except capture of an in-flight byte
//   bus   - if_fetch_unit_if.master: memory request/grant/data, redirect, IF/ID handshake
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    if_fetch_unit_if.master  bus
);

    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  issue_idx_q, issue_idx_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;

    logic req;
    logic issue;
    logic accept;
    logic redirect;
    logic capture;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            issue_idx_q <= 3'd0;
            pend_q      <= 1'b0;
            pend_idx_q  <= 2'd0;
            buf_q       <= 24'd0;
            inst_q      <= 32'd0;
            inst_pc_q   <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_idx_q <= issue_idx_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            buf_q       <= buf_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issue_idx_d = issue_idx_q;
        // A pending byte is always consumed (captured or discarded) on the following edge.
        pend_d      = 1'b0;
        pend_idx_d  = pend_idx_q;
        buf_d       = buf_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        valid_d     = valid_q;

        issue    = req && bus.if_grant_i;
        accept   = valid_q && !bus.stall_i;
        redirect = rdy && bus.jump_i;
        // Capture is independent of rdy; a redirect throws the in-flight byte away.
        capture  = pend_q && !redirect;

        if (capture) begin
            unique case (pend_idx_q)
                2'd0: buf_d[7:0]   = bus.mem_din_i;
                2'd1: buf_d[15:8]  = bus.mem_din_i;
                2'd2: buf_d[23:16] = bus.mem_din_i;
                2'd3: begin
                    inst_d    = {bus.mem_din_i, buf_q};
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    state_d   = StHold;
                end
                default: ;
            endcase
        end

        if (issue) begin
            issue_idx_d = issue_idx_q + 3'd1;
            pend_d      = 1'b1;
            pend_idx_d  = issue_idx_q[1:0];
        end

        if (rdy && (state_q == StHold) && accept) begin
            pc_d        = pc_q + 32'd4;
            valid_d     = 1'b0;
            issue_idx_d = 3'd0;
            state_d     = StFetch;
        end

        // Redirect overrides everything above; an acceptance in the same cycle still counts.
        if (redirect) begin
            pc_d        = bus.jump_addr_i;
            state_d     = StFetch;
            issue_idx_d = 3'd0;
            pend_d      = 1'b0;
            valid_d     = 1'b0;
        end
    end

    // Output logic
    always_comb begin
        // Gated by rst_n so no request leaks out while reset is held.
        req = rst_n && rdy && (state_q == StFetch) && (issue_idx_q < 3'd4);

        bus.if_request_o = req;
        bus.if_addr_o    = pc_q + {29'd0, issue_idx_q};
        bus.inst_valid_o = valid_q;
        bus.inst_o       = inst_q;
        bus.inst_pc_o    = inst_pc_q;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a table of fetch scenarios plus hand-written sequences
// for mid-fetch redirect and reset in the middle of a fetch / during hold.
module tb_if_fetch_unit;

    logic clk;
    logic rst_n;
    logic rdy;
    logic grant_en;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.if_grant_i = bus.if_request_o & grant_en;

    // RAM contents: 13,00,00,00 at 0..3, otherwise low address byte + 0x10.
    function automatic logic [7:0] ram(input logic [31:0] a);
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        return a[7:0] + 8'h10;
    endfunction

    logic [31:0] addr_log [$];

    always @(posedge clk) begin
        if (bus.if_request_o && bus.if_grant_i) begin
            bus.mem_din_i <= ram(bus.if_addr_o);
            addr_log.push_back(bus.if_addr_o);
        end else begin
            bus.mem_din_i <= 8'hEE;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one fetch starting in its first request cycle; gs/gl drop grant, rs/rl drop rdy
    // (with a jump to 0x300 asserted meanwhile, which must be ignored).
    task automatic do_fetch(input string name, input logic [31:0] exp_pc,
                            input logic [31:0] exp_inst, input int exp_lat,
                            input int gs, input int gl, input int rs, input int rl);
        int n;
        n = 0;
        addr_log.delete();
        chk({name, "_valid_start"}, {31'd0, bus.inst_valid_o}, 32'd0);
        while (!bus.inst_valid_o && n < 40) begin
            grant_en        = !(n >= gs && n < gs + gl);
            rdy             = !(n >= rs && n < rs + rl);
            bus.jump_i      = !rdy;
            bus.jump_addr_i = 32'h0000_0300;
            #1;
            if (!rdy)
                chk({name, "_req_rdy_low"}, {31'd0, bus.if_request_o}, 32'd0);
            else if (bus.if_request_o)
                chk({name, "_addr"}, bus.if_addr_o, exp_pc + 32'(addr_log.size()));
            step();
            n++;
        end
        grant_en   = 1'b1;
        rdy        = 1'b1;
        bus.jump_i = 1'b0;
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_inst"}, bus.inst_o, exp_inst);
        chk({name, "_inst_pc"}, bus.inst_pc_o, exp_pc);
        chk({name, "_nbytes"}, 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < addr_log.size() && i < 4; i++)
            chk({name, "_byte_addr"}, addr_log[i], exp_pc + 32'(i));
    endtask

    typedef struct {
        string       name;
        logic        do_jump;
        logic [31:0] jump_addr;
        int          stall_len;
        int          gs;
        int          gl;
        int          rs;
        int          rl;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;

        vecs[0] = '{"stall4",   1'b0, 32'h0,         4, 0, 0, 0, 0,
                    32'h0000_0004, 32'h1716_1514, 5};
        vecs[1] = '{"preempt",  1'b0, 32'h0,         0, 2, 3, 0, 0,
                    32'h0000_0008, 32'h1B1A_1918, 8};
        vecs[2] = '{"jmp100",   1'b1, 32'h0000_0100, 1, 0, 0, 0, 0,
                    32'h0000_0100, 32'h1312_1110, 5};
        vecs[3] = '{"wrap",     1'b1, 32'hFFFF_FFFE, 0, 0, 1, 0, 0,
                    32'hFFFF_FFFE, 32'h0013_0F0E, 6};
        vecs[4] = '{"afterwrap", 1'b0, 32'h0,        0, 0, 0, 0, 0,
                    32'h0000_0002, 32'h1514_0000, 5};
        vecs[5] = '{"unaligned", 1'b1, 32'h0000_0203, 0, 3, 2, 0, 0,
                    32'h0000_0203, 32'h1615_1413, 7};
        vecs[6] = '{"rdylow",   1'b0, 32'h0,         0, 0, 0, 1, 2,
                    32'h0000_0207, 32'h1A19_1817, 7};

        // Reset
        rst_n           = 1'b0;
        rdy             = 1'b1;
        grant_en        = 1'b1;
        bus.jump_i      = 1'b0;
        bus.jump_addr_i = 32'h0;
        bus.stall_i     = 1'b1;
        #1;
        chk("rst_req_low", {31'd0, bus.if_request_o}, 32'd0);
        step();
        chk("rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("rst_inst", bus.inst_o, 32'd0);
        chk("rst_inst_pc", bus.inst_pc_o, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_first_addr", bus.if_addr_o, 32'd0);
        chk("rst_first_req", {31'd0, bus.if_request_o}, 32'd1);

        do_fetch("basic", 32'h0, 32'h0000_0013, 5, 0, 0, 0, 0);
        prev_inst = 32'h0000_0013;
        prev_pc   = 32'h0;

        for (int v = 0; v < 7; v++) begin
            bus.stall_i = 1'b1;
            for (int k = 0; k < vecs[v].stall_len; k++) begin
                chk({vecs[v].name, "_hold_valid"}, {31'd0, bus.inst_valid_o}, 32'd1);
                chk({vecs[v].name, "_hold_req"}, {31'd0, bus.if_request_o}, 32'd0);
                chk({vecs[v].name, "_hold_inst"}, bus.inst_o, prev_inst);
                chk({vecs[v].name, "_hold_pc"}, bus.inst_pc_o, prev_pc);
                step();
            end
            bus.stall_i     = 1'b0;
            bus.jump_i      = vecs[v].do_jump;
            bus.jump_addr_i = vecs[v].jump_addr;
            step();
            bus.jump_i  = 1'b0;
            bus.stall_i = 1'b1;
            do_fetch(vecs[v].name, vecs[v].exp_pc, vecs[v].exp_inst, vecs[v].exp_lat,
                     vecs[v].gs, vecs[v].gl, vecs[v].rs, vecs[v].rl);
            prev_inst = vecs[v].exp_inst;
            prev_pc   = vecs[v].exp_pc;
        end

        // Redirect in the cycle after byte 2 issues; byte 2 and the byte 3 grant are dropped.
        bus.stall_i = 1'b0;
        step();
        bus.stall_i = 1'b1;
        addr_log.delete();
        chk("jmid_start_addr", bus.if_addr_o, 32'h0000_020B);
        step();
        step();
        step();
        chk("jmid_issued", 32'(addr_log.size()), 32'd3);
        bus.jump_i      = 1'b1;
        bus.jump_addr_i = 32'h0000_0100;
        step();
        bus.jump_i = 1'b0;
        chk("jmid_new_addr", bus.if_addr_o, 32'h0000_0100);
        do_fetch("jmid", 32'h0000_0100, 32'h1312_1110, 5, 0, 0, 0, 0);

        // Reset while byte 1 is being requested.
        bus.stall_i = 1'b0;
        step();
        bus.stall_i = 1'b1;
        chk("rstf_addr0", bus.if_addr_o, 32'h0000_0104);
        step();
        rst_n = 1'b0;
        #1;
        chk("rstf_req_low", {31'd0, bus.if_request_o}, 32'd0);
        step();
        chk("rstf_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("rstf_inst", bus.inst_o, 32'd0);
        rst_n = 1'b1;
        #1;
        do_fetch("rstf_refetch", 32'h0, 32'h0000_0013, 5, 0, 0, 0, 0);

        // Reset while holding a completed instruction.
        rst_n = 1'b0;
        step();
        chk("rsth_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("rsth_inst", bus.inst_o, 32'd0);
        chk("rsth_inst_pc", bus.inst_pc_o, 32'd0);
        rst_n = 1'b1;
        #1;
        do_fetch("rsth_refetch", 32'h0, 32'h0000_0013, 5, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
